// File: rtl/port_button_conditioner.sv
// rtl/port_button_conditioner.sv - button sync/debounce with sticky press interrupt flags
module port_button_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int CNT_W           = 16
) (
    input  logic             sys_clk,
    input  logic             rst_sync,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_rise,
    input  logic [N_BTN-1:0] irq_enable,
    input  logic             irq_ack,
    input  logic [N_BTN-1:0] irq_ack_mask,
    output logic [N_BTN-1:0] irq_pending,
    output logic             irq
);

    typedef enum logic [1:0] {
        LOW_STABLE,
        LOW_TO_HIGH,
        HIGH_STABLE,
        HIGH_TO_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [N_BTN-1:0] sync1_q, sync2_q;
    state_t           state_q [N_BTN];
    state_t           state_d [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [CNT_W-1:0] cnt_d   [N_BTN];
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] rise_q, rise_d;
    logic [N_BTN-1:0] pending_q, pending_d;
    logic             irq_q;

    // Counter is compared before incrementing, so it never exceeds CNT_LAST.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            rise_d[i]  = 1'b0;
            case (state_q[i])
                LOW_STABLE: begin
                    if (sync2_q[i]) begin
                        state_d[i] = LOW_TO_HIGH;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                LOW_TO_HIGH: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = LOW_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = HIGH_STABLE;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b1;
                        rise_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                HIGH_STABLE: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = HIGH_TO_LOW;
                        cnt_d[i]   = CNT_ONE;
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                HIGH_TO_LOW: begin
                    if (sync2_q[i]) begin
                        state_d[i] = HIGH_STABLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = LOW_STABLE;
                        cnt_d[i]   = '0;
                        level_d[i] = 1'b0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = LOW_STABLE;
                    cnt_d[i]   = '0;
                    level_d[i] = 1'b0;
                end
            endcase
        end
    end

    // A press landing in the same cycle as its ack keeps the bit set.
    always_comb begin
        pending_d = (pending_q & ~({N_BTN{irq_ack}} & irq_ack_mask)) | (rise_d & irq_enable);
    end

    always_ff @(posedge sys_clk) begin
        if (rst_sync) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            rise_q    <= '0;
            pending_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= LOW_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            rise_q    <= rise_d;
            pending_q <= pending_d;
            irq_q     <= |pending_q;
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_rise    = rise_q;
    assign irq_pending = pending_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_port_button_conditioner.sv
// tb/tb_port_button_conditioner.sv - directed self-checking bench for port_button_conditioner
module tb_port_button_conditioner;

    logic       sys_clk = 1'b0;
    logic       rst_sync;
    logic [2:0] btn_raw;
    logic [2:0] btn_level;
    logic [2:0] btn_rise;
    logic [2:0] irq_enable;
    logic       irq_ack;
    logic [2:0] irq_ack_mask;
    logic [2:0] irq_pending;
    logic       irq;

    int checks = 0;
    int errors = 0;

    port_button_conditioner #(
        .N_BTN          (3),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (8)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_sync    (rst_sync),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_rise    (btn_rise),
        .irq_enable  (irq_enable),
        .irq_ack     (irq_ack),
        .irq_ack_mask(irq_ack_mask),
        .irq_pending (irq_pending),
        .irq         (irq)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_sync     = 1'b1;
        btn_raw      = 3'b000;
        irq_enable   = 3'b111;
        irq_ack      = 1'b0;
        irq_ack_mask = 3'b000;
        step(3);
        chk("reset_level", btn_level, 3'b000);
        chk("reset_rise", btn_rise, 3'b000);
        chk("reset_pending", irq_pending, 3'b000);
        chk("reset_irq", {2'b00, irq}, 3'b000);
        rst_sync = 1'b0;

        // clean press on button 2, driven just after edge k
        btn_raw = 3'b100;
        step(5);
        chk("press_k5_level", btn_level, 3'b000);
        chk("press_k5_pending", irq_pending, 3'b000);
        step(1);
        chk("press_k6_level", btn_level, 3'b100);
        chk("press_k6_rise", btn_rise, 3'b100);
        chk("press_k6_pending", irq_pending, 3'b100);
        chk("press_k6_irq", {2'b00, irq}, 3'b000);
        step(1);
        chk("press_k7_rise", btn_rise, 3'b000);
        chk("press_k7_irq", {2'b00, irq}, 3'b001);

        // release button 2
        btn_raw = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("release_rise", btn_rise, 3'b000);
            chk("release_level_hold", btn_level, 3'b100);
        end
        step(1);
        chk("release_level", btn_level, 3'b000);
        chk("release_rise_fall", btn_rise, 3'b000);
        chk("release_pending", irq_pending, 3'b100);
        chk("release_irq", {2'b00, irq}, 3'b001);

        irq_ack      = 1'b1;
        irq_ack_mask = 3'b100;
        step(1);
        irq_ack = 1'b0;
        chk("ack2_pending", irq_pending, 3'b000);
        chk("ack2_irq_lag", {2'b00, irq}, 3'b001);
        step(1);
        chk("ack2_irq", {2'b00, irq}, 3'b000);

        // bounce on button 0: 1,1,1,0 repeated
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 4; p++) begin
                btn_raw = (p == 3) ? 3'b000 : 3'b001;
                step(1);
                chk("bounce_level", btn_level, 3'b000);
                chk("bounce_rise", btn_rise, 3'b000);
            end
        end
        btn_raw = 3'b001;
        step(5);
        chk("bounce_hold5_level", btn_level, 3'b000);
        step(1);
        chk("bounce_hold6_level", btn_level, 3'b001);
        chk("bounce_hold6_rise", btn_rise, 3'b001);
        chk("bounce_hold6_pending", irq_pending, 3'b001);
        irq_ack      = 1'b1;
        irq_ack_mask = 3'b001;
        step(1);
        irq_ack = 1'b0;
        chk("ack0_pending", irq_pending, 3'b000);
        btn_raw = 3'b000;
        step(7);
        chk("bounce_release_level", btn_level, 3'b000);
        chk("bounce_release_irq", {2'b00, irq}, 3'b000);

        // ack/set collision on button 1
        btn_raw = 3'b010;
        step(6);
        chk("coll_first_pending", irq_pending, 3'b010);
        btn_raw = 3'b000;
        step(7);
        chk("coll_release_level", btn_level, 3'b000);
        chk("coll_before_irq", {2'b00, irq}, 3'b001);
        btn_raw = 3'b010;
        step(5);
        irq_ack      = 1'b1;
        irq_ack_mask = 3'b010;
        step(1);
        irq_ack = 1'b0;
        chk("coll_rise", btn_rise, 3'b010);
        chk("coll_pending", irq_pending, 3'b010);
        chk("coll_irq", {2'b00, irq}, 3'b001);
        btn_raw = 3'b000;
        step(7);
        chk("coll_hold_pending", irq_pending, 3'b010);
        irq_ack      = 1'b1;
        irq_ack_mask = 3'b111;
        step(1);
        irq_ack = 1'b0;
        chk("ackall_pending", irq_pending, 3'b000);
        chk("ackall_irq_lag", {2'b00, irq}, 3'b001);
        step(1);
        chk("ackall_irq", {2'b00, irq}, 3'b000);

        // enable masking on button 0
        irq_enable = 3'b110;
        btn_raw    = 3'b001;
        step(6);
        chk("mask_rise", btn_rise, 3'b001);
        chk("mask_pending", irq_pending, 3'b000);
        step(1);
        chk("mask_irq", {2'b00, irq}, 3'b000);
        chk("mask_pending2", irq_pending, 3'b000);
        btn_raw = 3'b000;
        step(7);
        irq_enable = 3'b111;

        // reset while button 1 is mid-debounce with pending=001
        btn_raw = 3'b001;
        step(6);
        chk("pre_reset_pending", irq_pending, 3'b001);
        btn_raw = 3'b000;
        step(7);
        btn_raw = 3'b010;
        step(4);
        chk("pre_reset_level", btn_level, 3'b000);
        rst_sync = 1'b1;
        step(1);
        rst_sync = 1'b0;
        chk("midrst_level", btn_level, 3'b000);
        chk("midrst_rise", btn_rise, 3'b000);
        chk("midrst_pending", irq_pending, 3'b000);
        chk("midrst_irq", {2'b00, irq}, 3'b000);
        step(5);
        chk("postrst5_level", btn_level, 3'b000);
        step(1);
        chk("postrst6_level", btn_level, 3'b010);
        chk("postrst6_pending", irq_pending, 3'b010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
